// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus masters.
// Contents: sequencer state encoding, default phase timings, bus idle
// levels, and a small max helper used to size the phase timer.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR_WR  = 3'd1,
    S_ADDR_REL = 3'd2,
    S_DATA_WR  = 3'd3,
    S_DATA_REL = 3'd4,
    S_DONE     = 3'd5
  } rtc_state_e;

  localparam int T_PHASE_DEF = 4;
  localparam int T_GAP_DEF   = 2;

  localparam logic CS_IDLE = 1'b1;
  localparam logic WR_IDLE = 1'b1;
  localparam logic RD_IDLE = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rtc_write_sequencer_timer.sv
// rtc_phase_timer: loadable down-counter timing one bus phase.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   load  in  load the counter with len-1 this cycle
//   len   in  phase length in clock cycles (>=1)
//   zero  out counter currently reads 0 (last cycle of the phase)
// The counter holds at 0 rather than wrapping, so an idle timer stays quiet.
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer: write-side master for the RTC multiplexed AD bus.
// Takes one (addr, data) request and runs a timed address phase followed by
// a data phase, each with a wr_n low pulse and a release gap.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start             write request, only looked at in IDLE
//   in_addr, in_dato  address/data, captured on acceptance
//   busy, done        busy from acceptance+1 through DONE; done pulse in DONE
//   ad_out, ad_oe     AD bus value and output enable
//   cs_n, rd_n, wr_n  RTC strobes (rd_n is never asserted here)
//   a_d               0 = address phase, 1 = data phase
//
// state      | meaning
// S_IDLE     | bus released, waiting for start
// S_ADDR_WR  | address driven, wr_n low for T_PHASE cycles
// S_ADDR_REL | address still driven, wr_n high for T_GAP cycles
// S_DATA_WR  | data driven, wr_n low for T_PHASE cycles
// S_DATA_REL | data still driven, wr_n high for T_GAP cycles
// S_DONE     | bus released, one-cycle done pulse
module rtc_write_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int N       = 8,
  parameter int T_PHASE = T_PHASE_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] in_addr,
  input  logic [N-1:0] in_dato,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] ad_out,
  output logic         ad_oe,
  output logic         cs_n,
  output logic         rd_n,
  output logic         wr_n,
  output logic         a_d
);

  localparam int CW = $clog2(max_int(T_PHASE, T_GAP) + 1);

  rtc_state_e    state, state_nxt;
  logic [N-1:0]  addr_q, data_q;
  logic          accept;
  logic          tmr_load;
  logic [CW-1:0] tmr_len;
  logic          tmr_zero;

  rtc_phase_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .len   (tmr_len),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= in_addr;
        data_q <= in_dato;
      end
    end
  end

  // Each phase reloads the timer on entry; the final gap needs no reload
  // since DONE always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmr_load  = 1'b0;
    tmr_len   = CW'(T_PHASE);
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = S_ADDR_WR;
        end
      end
      S_ADDR_WR: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_len   = CW'(T_GAP);
          state_nxt = S_ADDR_REL;
        end
      end
      S_ADDR_REL: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          state_nxt = S_DATA_WR;
        end
      end
      S_DATA_WR: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_len   = CW'(T_GAP);
          state_nxt = S_DATA_REL;
        end
      end
      S_DATA_REL: begin
        if (tmr_zero) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs depend on state and the captured latches only, so an async
  // reset releases the bus in the same cycle.
  always_comb begin
    cs_n   = CS_IDLE;
    wr_n   = WR_IDLE;
    rd_n   = RD_IDLE;
    ad_oe  = 1'b0;
    a_d    = 1'b1;
    ad_out = '0;
    busy   = (state != S_IDLE);
    done   = 1'b0;
    case (state)
      S_ADDR_WR: begin
        cs_n = 1'b0; wr_n = 1'b0; ad_oe = 1'b1; a_d = 1'b0; ad_out = addr_q;
      end
      S_ADDR_REL: begin
        cs_n = 1'b0; ad_oe = 1'b1; a_d = 1'b0; ad_out = addr_q;
      end
      S_DATA_WR: begin
        cs_n = 1'b0; wr_n = 1'b0; ad_oe = 1'b1; ad_out = data_q;
      end
      S_DATA_REL: begin
        cs_n = 1'b0; ad_oe = 1'b1; ad_out = data_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
